// File: rtl/video_stream_gen.sv
// Raster timing and test-pattern generator: sync, back porch, active, front porch.
// Define VIDEO_STREAM_GEN_SCROLL_EN to scroll the ramp patterns one pixel per frame.
module video_stream_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] solid_val,
  output logic       Y_de,
  output logic       Y_hsync,
  output logic       Y_vsync,
  output logic [7:0] Y_data,
  output logic       frame_done
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_DISP;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_DISP;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        h_last, v_last, in_run, frame_start, frame_last;

  logic [1:0]  pat_lat;
  logic [7:0]  solid_lat;
  logic [1:0]  pat_eff;
  logic [7:0]  solid_eff;
  logic [7:0]  scroll_off;

  logic        hsync_p0, vsync_p0, de_p0;
  logic [7:0]  x_p0, y_p0, pix_p0;

  function automatic logic [7:0] pixel_val(input logic [1:0] pat,
                                           input logic [7:0] sv,
                                           input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic [7:0] offs);
    logic [7:0] p;
    case (pat)
      2'd0:    p = x + offs;
      2'd1:    p = y + offs;
      2'd2:    p = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: p = sv;
    endcase
    return p;
  endfunction

  assign in_run      = (state == RUN);
  assign h_last      = (h_cnt == 12'(H_TOTAL - 1));
  assign v_last      = (v_cnt == 12'(V_TOTAL - 1));
  assign frame_start = in_run && (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign frame_last  = in_run && h_last && v_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // A frame always runs to its last cycle; en is only sampled there.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE: begin
        h_nxt = 12'd0;
        v_nxt = 12'd0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_nxt = 12'd0;
          v_nxt = v_last ? 12'd0 : v_cnt + 12'd1;
          if (v_last && !en) state_nxt = IDLE;
        end else begin
          h_nxt = h_cnt + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_lat   <= 2'd0;
      solid_lat <= 8'h00;
    end else if (frame_start) begin
      pat_lat   <= pattern_sel;
      solid_lat <= solid_val;
    end
  end

  // The frame-start cycle already sees this frame's selection.
  assign pat_eff   = frame_start ? pattern_sel : pat_lat;
  assign solid_eff = frame_start ? solid_val   : solid_lat;

`ifdef VIDEO_STREAM_GEN_SCROLL_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= 8'h00;
    else if (frame_last) frame_cnt <= frame_cnt + 8'h01;
  end

  assign scroll_off = frame_cnt;
`else
  assign scroll_off = 8'h00;
`endif

  // Stage p0: combinational decode of the counters
  assign hsync_p0 = in_run && (h_cnt < 12'(H_SYNC));
  assign vsync_p0 = in_run && (v_cnt < 12'(V_SYNC));
  assign de_p0    = in_run &&
                    (h_cnt >= 12'(H_ACT_START)) && (h_cnt < 12'(H_ACT_END)) &&
                    (v_cnt >= 12'(V_ACT_START)) && (v_cnt < 12'(V_ACT_END));
  assign x_p0     = h_cnt[7:0] - 8'(H_ACT_START);
  assign y_p0     = v_cnt[7:0] - 8'(V_ACT_START);
  assign pix_p0   = pixel_val(pat_eff, solid_eff, x_p0, y_p0, scroll_off);

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_hsync    <= 1'b0;
      Y_vsync    <= 1'b0;
      Y_de       <= 1'b0;
      Y_data     <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      Y_hsync    <= hsync_p0;
      Y_vsync    <= vsync_p0;
      Y_de       <= de_p0;
      Y_data     <= de_p0 ? pix_p0 : 8'h00;
      frame_done <= frame_last;
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen using a 14x7 raster.
module tb_video_stream_gen;

  localparam int HT = 14;
  localparam int VT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] solid_val = 8'h00;
  logic       Y_de, Y_hsync, Y_vsync, frame_done;
  logic [7:0] Y_data;

  int total = 0;
  int bad = 0;
  int n_hs, n_vs, n_de, n_fd;

  video_stream_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .solid_val(solid_val),
    .Y_de(Y_de), .Y_hsync(Y_hsync), .Y_vsync(Y_vsync), .Y_data(Y_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int offs(input int f);
`ifdef VIDEO_STREAM_GEN_SCROLL_EN
    return f;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " de"}, 32'(Y_de), 32'd0);
    chk({tag, " hsync"}, 32'(Y_hsync), 32'd0);
    chk({tag, " vsync"}, 32'(Y_vsync), 32'd0);
    chk({tag, " data"}, 32'(Y_data), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic reset_counts();
    n_hs = 0; n_vs = 0; n_de = 0; n_fd = 0;
  endtask

  // Expected outputs for frame position t (h = t%14, v = t/14), active window h 4..11, v 2..5.
  task automatic check_cycle(input int t, input int pat, input logic [7:0] sv, input int off);
    int h, v;
    logic hs_e, vs_e, de_e, fd_e;
    logic [7:0] d_e;
    h = t % HT;
    v = t / HT;
    hs_e = (h < 2);
    vs_e = (v < 1);
    de_e = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    fd_e = (t == HT * VT - 1);
    d_e = 8'h00;
    if (de_e) begin
      case (pat)
        0: d_e = 8'((h - 4 + off) & 255);
        1: d_e = 8'((v - 2 + off) & 255);
        2: d_e = ((((h - 4) >> 3) ^ ((v - 2) >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
        default: d_e = sv;
      endcase
    end
    chk($sformatf("hsync t=%0d", t), 32'(Y_hsync), 32'(hs_e));
    chk($sformatf("vsync t=%0d", t), 32'(Y_vsync), 32'(vs_e));
    chk($sformatf("de t=%0d", t), 32'(Y_de), 32'(de_e));
    chk($sformatf("data t=%0d pat=%0d", t, pat), 32'(Y_data), 32'(d_e));
    chk($sformatf("frame_done t=%0d", t), 32'(frame_done), 32'(fd_e));
    n_hs += int'(Y_hsync);
    n_vs += int'(Y_vsync);
    n_de += int'(Y_de);
    n_fd += int'(frame_done);
  endtask

  task automatic run_span(input int pat, input logic [7:0] sv, input int off,
                          input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      check_cycle(t, pat, sv, off);
      @(negedge clk);
    end
  endtask

  task automatic frame_totals(input string tag);
    chk({tag, " hsync count"}, 32'(n_hs), 32'd14);
    chk({tag, " vsync count"}, 32'(n_vs), 32'd14);
    chk({tag, " de count"}, 32'(n_de), 32'd32);
    chk({tag, " frame_done count"}, 32'(n_fd), 32'd1);
    reset_counts();
  endtask

  initial begin
    reset_counts();
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle");

    en = 1'b1;
    pattern_sel = 2'd0;
    @(negedge clk);
    check_zero("start_latency");
    @(negedge clk);

    // Frame 0: h-ramp; request v-ramp mid-frame.
    run_span(0, 8'h00, offs(0), 0, 19);
    pattern_sel = 2'd1;
    run_span(0, 8'h00, offs(0), 20, 97);
    frame_totals("f0");

    // Frame 1: v-ramp.
    run_span(1, 8'h00, offs(1), 0, 19);
    pattern_sel = 2'd2;
    run_span(1, 8'h00, offs(1), 20, 97);
    frame_totals("f1");

    // Frame 2: checker; request solid 5A.
    run_span(2, 8'h00, offs(2), 0, 19);
    pattern_sel = 2'd3;
    solid_val = 8'h5A;
    run_span(2, 8'h00, offs(2), 20, 97);
    frame_totals("f2");

    // Frame 3: solid 5A, switched to ramp at clock 40 without effect on this frame.
    run_span(3, 8'h5A, offs(3), 0, 39);
    pattern_sel = 2'd0;
    solid_val = 8'h33;
    run_span(3, 8'h5A, offs(3), 40, 97);
    frame_totals("f3");

    // Frame 4: ramp, en dropped at clock 40; frame must complete then go idle.
    run_span(0, 8'h00, offs(4), 0, 39);
    en = 1'b0;
    run_span(0, 8'h00, offs(4), 40, 97);
    frame_totals("f4");
    check_zero("stopped0");
    @(negedge clk);
    check_zero("stopped1");
    @(negedge clk);
    check_zero("stopped2");

    // Frame 5: restart, then async reset at clock 50.
    en = 1'b1;
    @(negedge clk);
    check_zero("restart_latency");
    @(negedge clk);
    run_span(0, 8'h00, offs(5), 0, 49);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    check_zero("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_release");
    @(negedge clk);
    reset_counts();
    run_span(0, 8'h00, offs(0), 0, 97);
    frame_totals("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_DISP, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in clocks.
- H_SYNC, 96, hsync width in clocks.
- H_BACK, 48, horizontal back porch in clocks.
- V_DISP, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, run request.
- pattern_sel, in, 2, pattern select: 0 h-ramp, 1 v-ramp, 2 checker, 3 solid.
- solid_val, in, 8, pixel value for pattern 3.
- Y_de, out, 1, active-pixel strobe.
- Y_hsync, out, 1, line sync, active-high.
- Y_vsync, out, 1, frame sync, active-high.
- Y_data, out, 8, pixel value; valid when Y_de=1.
- frame_done, out, 1, one-cycle pulse on the last clock of each frame.

Function
REQ-003 H_TOTAL SHALL equal H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL SHALL equal V_SYNC+V_BACK+V_DISP+V_FRONT.
REQ-004 Counter widths SHALL be 12 bits.
- h_cnt SHALL count 0..H_TOTAL-1, then wrap to 0.
- v_cnt SHALL increment on every h_cnt wrap, and wrap to 0 after V_TOTAL-1.
REQ-005 Region order within a line and within a frame SHALL be: sync, back porch, active, front porch.
REQ-006 The FSM SHALL have two states, IDLE and RUN.
- IDLE->RUN: on en=1; the first RUN cycle SHALL have h_cnt=0, v_cnt=0.
- RUN->IDLE: only on the last frame cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) when en=0.
- Deasserting en mid-frame SHALL NOT truncate the frame.
REQ-007 In IDLE, counters SHALL hold 0 and all outputs SHALL be 0.
REQ-008 All outputs SHALL be registered decodes of the counters, with exactly 1 clock of latency:
- Y_hsync = (h_cnt < H_SYNC).
- Y_vsync = (v_cnt < V_SYNC).
- Y_de = both counters inside their active windows.
REQ-009 Pixel coordinates SHALL be x = h_cnt-(H_SYNC+H_BACK) and y = v_cnt-(V_SYNC+V_BACK).
REQ-010 Y_data SHALL be computed from x and y as follows:
- h-ramp: x[7:0].
- v-ramp: y[7:0].
- checker: 8'hFF when x[3]^y[3]=1, else 8'h00.
- solid: solid_val.
REQ-011 Y_data SHALL be 8'h00 whenever Y_de=0.
REQ-012 pattern_sel and solid_val SHALL be latched only at frame start (RUN with h_cnt=0, v_cnt=0); changes mid-frame SHALL take effect from the next frame.
REQ-013 frame_done SHALL assert for exactly one clock, aligned with the registered output of the last frame cycle. It SHALL still pulse when the FSM returns to IDLE.
REQ-014 Back-to-back frames with en held at 1 SHALL have no gap: the cycle after the last frame cycle SHALL be h_cnt=0, v_cnt=0.

Reset
REQ-015 rst=1 SHALL immediately and asynchronously force the following, regardless of current position, including mid-frame:
- state=IDLE and both counters to 0.
- Y_de, Y_hsync, Y_vsync, frame_done to 0 and Y_data to 8'h00.
- latched pattern to 0 and latched solid value to 8'h00.
REQ-016 After rst deasserts, the block SHALL start a new frame from h_cnt=0 only via the IDLE->RUN rule.

Configuration
REQ-017 Macro VIDEO_STREAM_GEN_SCROLL_EN SHALL control pattern scrolling.
- Defined: an 8-bit frame counter SHALL reset to 0 and increment on each frame_done. Its value SHALL be added modulo 256 to x for h-ramp and to y for v-ramp, so patterns scroll one pixel per frame. Checker and solid SHALL be unaffected.
- Undefined: the frame counter SHALL be absent and all patterns SHALL be static.

Verification
(Bench parameters: H_DISP=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_DISP=4, V_FRONT=1, V_SYNC=1, V_BACK=1; so H_TOTAL=14, V_TOTAL=7.)
REQ-018 Timing: en=1 continuously. Required response:
- Y_hsync high for 2 of every 14 clocks.
- Y_vsync high for 14 clocks every 98.
- Y_de high for 8-clock runs on 4 lines per frame.
- frame_done pulses every 98 clocks.
REQ-019 Pattern: pattern_sel=0. Required response: Y_data on each active line SHALL be 0,1,...,7. With pattern_sel=1, line k SHALL carry 8 copies of k.
REQ-020 Latch: pattern_sel changed 3->0 mid-frame with solid_val=8'h5A. Required response: the rest of the current frame SHALL be 8'h5A; the next frame SHALL be the ramp.
REQ-021 Stop: en dropped at clock 40 of a frame. Required response: the frame SHALL complete, frame_done SHALL pulse, and the block SHALL go IDLE with all outputs 0.
REQ-022 Reset: rst pulsed at clock 50 of a frame. Required response: all outputs SHALL be 0 within the same cycle; after release with en=1, a full frame SHALL start with Y_hsync high for 2 clocks.
REQ-023 With VIDEO_STREAM_GEN_SCROLL_EN defined and pattern_sel=0, frame 2 SHALL carry 2,3,...,9 on each active line.
